// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Define PS2_TX_RETRY_EN to retry once (same byte) after a timeout or NACK before flagging TX_ERR.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         bitcnt_q;
  logic [7:0]         byte_q;
  logic               par_q;
  logic               clk_s1_q, clk_s2_q, clk_prev_q;
  logic               dat_s1_q, dat_s2_q;
  logic               clk_oe_q, data_oe_q, done_q, err_q;

  logic [9:0]         frame;
  logic               clk_fall, bus_idle, to_hit, fail, retry_ok;

`ifdef PS2_TX_RETRY_EN
  logic               retried_q;
  assign retry_ok = ~retried_q;
`else
  assign retry_ok = 1'b0;
`endif

  // Bits driven on falling edges 1..10: data LSB first, odd parity, stop.
  assign frame = {1'b1, par_q, byte_q};

  always_comb begin
    clk_fall = clk_prev_q & ~clk_s2_q;
    bus_idle = clk_s2_q & dat_s2_q;
    to_hit   = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    fail     = 1'b0;
    // A falling edge (or bus-idle completion) takes priority over a coincident timeout.
    case (state_q)
      S_RTS, S_SHIFT: fail = ~clk_fall & to_hit;
      S_ACK:          fail = clk_fall ? dat_s2_q : to_hit;
      S_WAIT_IDLE:    fail = ~bus_idle & to_hit;
      default:        fail = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retried_q  <= 1'b0;
`endif
    end else begin
      clk_s1_q   <= PS2_CLK;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DATA;
      dat_s2_q   <= dat_s1_q;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      if (fail) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        cnt_q     <= '0;
        bitcnt_q  <= '0;
        if (retry_ok) begin
          // Lines stay released for one cycle; INHIBIT re-asserts the clock on entry.
          state_q <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retried_q <= 1'b1;
`endif
        end else begin
          err_q   <= 1'b1;
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (TX_VALID) begin
              byte_q    <= TX_DATA;
              par_q     <= ~^TX_DATA;
              cnt_q     <= '0;
              bitcnt_q  <= '0;
              clk_oe_q  <= 1'b1;
              data_oe_q <= (INHIBIT_CYCLES == 1);
              state_q   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
              retried_q <= 1'b0;
`endif
            end
          end
          S_INHIBIT: begin
            if (!clk_oe_q) begin
              clk_oe_q  <= 1'b1;
              data_oe_q <= (INHIBIT_CYCLES == 1);
            end else if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= S_RTS;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2))
                data_oe_q <= 1'b1;
            end
          end
          S_RTS, S_SHIFT: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (clk_fall) begin
              data_oe_q <= ~frame[bitcnt_q];
              bitcnt_q  <= bitcnt_q + 4'd1;
              state_q   <= (bitcnt_q == 4'd9) ? S_ACK : S_SHIFT;
            end
          end
          S_ACK: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (clk_fall)
              state_q <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: begin
            if (bus_idle) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign TX_READY    = (state_q == S_IDLE);
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;
  assign TX_DONE     = done_q;
  assign TX_ERR      = err_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL provide parameter INHIBIT_CYCLES, default 5000, CLK cycles PS2_CLK is held low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1000000, maximum CLK cycles from request-to-send to ACK (20 ms at 50 MHz).
REQ-003 SHALL provide port CLK  input  1  board clock; single clock domain for all logic.
REQ-004 SHALL provide port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port TX_DATA  input  8  byte to send to the keyboard.
REQ-006 SHALL provide port TX_VALID  input  1  send request; byte accepted when TX_VALID && TX_READY.
REQ-007 SHALL provide port TX_READY  output  1  high only in IDLE.
REQ-008 SHALL provide port PS2_CLK  input  1  keyboard clock line, read back.
REQ-009 SHALL provide port PS2_DATA  input  1  keyboard data line, read back.
REQ-010 SHALL provide port PS2_CLK_OE  output  1  1 = drive clock line low, 0 = release.
REQ-011 SHALL provide port PS2_DATA_OE  output  1  1 = drive data line low, 0 = release.
REQ-012 SHALL provide port TX_DONE  output  1  one-cycle pulse, byte sent and ACKed.
REQ-013 SHALL provide port TX_ERR  output  1  one-cycle pulse, timeout or NACK.

Function
REQ-014 SHALL synchronise PS2_CLK and PS2_DATA through two flops each; falling edge = previous synced 1, current synced 0.
REQ-015 SHALL latch TX_DATA on acceptance and compute odd parity (parity = NOT XOR of the 8 bits).
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: both OE 0; acceptance -> INHIBIT next cycle.
REQ-018 INHIBIT: PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles; PS2_DATA_OE=1 on the last of them; then -> RTS.
REQ-019 RTS: PS2_CLK_OE=0, PS2_DATA_OE=1 (start bit 0); timeout counter starts from 0; first falling edge -> SHIFT.
REQ-020 SHIFT: on falling edges 1-8 drive data bit 0..7 (LSB first); edge 9 parity; edge 10 stop (PS2_DATA_OE=0); PS2_DATA_OE = NOT bit value; then -> ACK.
REQ-021 ACK: on falling edge 11 sample synced PS2_DATA; 0 -> WAIT_IDLE, 1 -> NACK error.
REQ-022 WAIT_IDLE: when synced PS2_CLK and PS2_DATA both 1, pulse TX_DONE and -> IDLE.
REQ-023 Timeout counter exceeding TIMEOUT_CYCLES in RTS/SHIFT/ACK/WAIT_IDLE SHALL release both OE in the same cycle, pulse TX_ERR, -> IDLE.
REQ-024 Falling edge and timeout in the same cycle: edge wins.
REQ-025 Falling edges seen during IDLE/INHIBIT SHALL be ignored.
REQ-026 TX_VALID while TX_READY=0 SHALL be ignored; TX_DONE/TX_ERR never both in one cycle.

Reset
REQ-027 RST SHALL immediately force IDLE, PS2_CLK_OE=0, PS2_DATA_OE=0, TX_DONE=0, TX_ERR=0, TX_READY=1, counters 0, synchroniser flops 1.
REQ-028 RST mid-transfer SHALL abandon the byte with no TX_DONE/TX_ERR pulse.

Configuration
REQ-029 With PS2_TX_RETRY_EN defined, first timeout or NACK SHALL release lines, re-enter INHIBIT with the same byte, and TX_ERR only on second failure; without it, first failure pulses TX_ERR.

Verification
REQ-030 TX_DATA=0xED, keyboard model clocks 11 edges, ACK low -> data bits 1,0,1,1,0,1,1,1, parity 1, stop released, TX_DONE one pulse, TX_READY high after.
REQ-031 TX_DATA=0xF4 -> PS2_CLK_OE high exactly 5000 cycles, PS2_DATA_OE rises on last, parity 0, TX_DONE.
REQ-032 TX_DATA=0xFF, model holds PS2_DATA high on edge 11 -> TX_ERR pulse (retry macro off); one retry then TX_ERR (on).
REQ-033 Model never clocks -> TX_ERR at 1000001 cycles after RTS, both OE 0 same cycle.
REQ-034 RST asserted after edge 5 -> both OE 0 asynchronously, no pulses, next 0xED sends correctly.
